// File: rtl/bypass_adder_s_c_pkg.sv
// Shared helpers for the carry-skip adder: block-count arithmetic used at elaboration.
package bypass_adder_s_c_pkg;

  function automatic int num_blocks(input int width, input int blk);
    return width / blk;
  endfunction

endpackage

// File: rtl/bypass_adder_s_c_block.sv
// One carry-skip block: BLOCK-bit ripple chain plus a propagate-controlled bypass mux.
module bypass_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic             rc;
  logic             blk_p;

  assign p     = a ^ b;
  assign g     = a & b;
  assign blk_p = &p;

  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = p[i] ^ c;
      c    = g[i] | (p[i] & c);
    end
    rc = c;
  end

  // When every bit propagates, the block carry-out equals its carry-in.
  assign co = blk_p ? ci : rc;

endmodule

// File: rtl/bypass_adder_s_c.sv
// Carry-skip adder built from bypass_block slices, with a registered {Cout,Sum}.
module bypass_adder_s_c
  import bypass_adder_s_c_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NB = num_blocks(WIDTH, BLOCK);

  generate
    if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_param_err
      $error("bypass_adder_s_c: WIDTH must be a positive multiple of BLOCK");
    end
  endgenerate

  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic ci;
    logic co;

    if (k == 0) begin : g_first
      assign ci = Cin;
    end else begin : g_next
      assign ci = g_blk[k-1].co;
    end

    bypass_block #(.BLOCK(BLOCK)) u_blk (
      .a  (A[k*BLOCK +: BLOCK]),
      .b  (B[k*BLOCK +: BLOCK]),
      .ci (ci),
      .s  (sum_comb[k*BLOCK +: BLOCK]),
      .co (co)
    );
  end

  always_comb begin
    sum_d  = sum_comb;
    cout_d = g_blk[NB-1].co;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_bypass_adder_s_c.sv
// Bench for bypass_adder_s_c: four block sizes share one stimulus stream and a plain-arithmetic model.
module tb_bypass_adder_s_c;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic        cin = 1'b0;

  logic [31:0] s1, s4, s8, s32;
  logic        c1, c4, c8, c32;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bypass_adder_s_c #(.WIDTH(32), .BLOCK(1))  u_b1  (.clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sum(s1),  .Cout(c1));
  bypass_adder_s_c #(.WIDTH(32), .BLOCK(4))  u_b4  (.clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sum(s4),  .Cout(c4));
  bypass_adder_s_c #(.WIDTH(32), .BLOCK(8))  u_b8  (.clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sum(s8),  .Cout(c8));
  bypass_adder_s_c #(.WIDTH(32), .BLOCK(32)) u_b32 (.clk(clk), .rst(rst), .A(a), .B(b), .Cin(cin), .Sum(s32), .Cout(c32));

  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  task automatic chk1(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed={%b,%h} expected={%b,%h}", tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic chk(input string tag, input logic [32:0] exp);
    chk1({tag, "/B1"},  {c1,  s1},  exp);
    chk1({tag, "/B4"},  {c4,  s4},  exp);
    chk1({tag, "/B8"},  {c8,  s8},  exp);
    chk1({tag, "/B32"}, {c32, s32}, exp);
  endtask

  // Apply a vector away from the edge, let one edge capture it, check 1 time unit later.
  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic ci,
                      input logic [32:0] exp, input string tag);
    a = x; b = y; cin = ci;
    @(posedge clk); #1;
    chk(tag, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] pend;

    #1 rst = 1'b1;
    #1 chk("reset_async", 33'h0_0000_0000);
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b1;
    @(posedge clk); #1;
    chk("reset_held", 33'h0_0000_0000);
    rst = 1'b0;

    step(32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002, "basic_1p1");
    step(32'h1234_5678, 32'h8765_4321, 1'b1, 33'h0_9999_999A, "basic_1234");
    step(32'h1111_1111, 32'h2222_2222, 1'b1, 33'h0_3333_3334, "basic_1111");
    step(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF, "skip_cin0");
    step(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000, "skip_cin1");
    step(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 33'h1_0000_0000, "skip_0_ffff");
    step(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, "wrap_ffff_1");
    step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE, "gen_ffff_ffff");
    step(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33'h1_7FFF_FFFF, "gen_8000_ffff");
    step(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, "ovf_7fff_1");
    step(32'h0000_0000, 32'h0000_0000, 1'b0, 33'h0_0000_0000, "zero");

    // Mid-stream reset: a pending result must be discarded.
    step(32'h0000_00FF, 32'h0000_0001, 1'b0, 33'h0_0000_0100, "pre_reset");
    a = 32'hDEAD_BEEF; b = 32'h1111_1111; cin = 1'b1;
    #2 rst = 1'b1;
    #1 chk("reset_mid_async", 33'h0_0000_0000);
    @(posedge clk); #1;
    chk("reset_mid_held", 33'h0_0000_0000);
    rst = 1'b0;
    step(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 33'h0_EFBE_D001, "post_reset");

    // Back-to-back random vectors, plus a biased mix that hits full-propagate blocks.
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom();
      case (i % 4)
        0:       rb = ~ra;
        1:       rb = ~ra ^ (32'h1 << $urandom_range(31, 0));
        default: rb = $urandom();
      endcase
      rc = 1'($urandom_range(1, 0));
      a = ra; b = rb; cin = rc;
      pend = model(ra, rb, rc);
      @(posedge clk); #1;
      chk("random", pend);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
